// File: rtl/m_stage.sv
// m_stage: RV32 memory stage issuing dmem requests and registering one write-back result per instruction
module m_stage #(
  parameter int N_BITS = 32,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  output logic               m_ready,
  input  logic [N_BITS-1:0]  x_data,
  input  logic [N_BITS-1:0]  x_store_data,
  input  logic [1:0]         x_mem_op,
  input  logic [1:0]         x_mem_size,
  input  logic               x_load_unsigned,
  input  logic [RD_BITS-1:0] x_rd,
  input  logic               x_rd_we,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic               dmem_req_we,
  output logic [N_BITS-1:0]  dmem_req_addr,
  output logic [N_BITS-1:0]  dmem_req_wdata,
  output logic [3:0]         dmem_req_be,
  input  logic               dmem_resp_valid,
  input  logic [N_BITS-1:0]  dmem_resp_data,
  output logic               w_valid,
  output logic [N_BITS-1:0]  w_data,
  output logic [RD_BITS-1:0] w_rd,
  output logic               w_rd_we,
  output logic               misalign_exc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;
  logic [N_BITS-1:0] addr_q, addr_d, wdata_q, wdata_d, w_data_q, w_data_d;
  logic [3:0] be_q, be_d;
  logic [1:0] size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, rd_we_q, rd_we_d;
  logic [RD_BITS-1:0] rd_q, rd_d, w_rd_q, w_rd_d;
  logic w_valid_q, w_valid_d, w_rd_we_q, w_rd_we_d, exc_q, exc_d;
  logic is_mem, bad;
  logic [3:0] be_x;
  logic [N_BITS-1:0] wdata_x, load_x;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  assign is_mem = (x_mem_op == 2'b01) || (x_mem_op == 2'b10);
  assign bad = (x_mem_size == 2'b11) || (x_mem_size == 2'b01 && x_data[0]) || (x_mem_size == 2'b10 && x_data[1:0] != 2'b00);
  assign be_x = x_mem_size == 2'b00 ? 4'b0001 << x_data[1:0] : x_mem_size == 2'b01 ? 4'b0011 << x_data[1:0] : 4'b1111;
  assign wdata_x = x_mem_size == 2'b00 ? {4{x_store_data[7:0]}} : x_mem_size == 2'b01 ? {2{x_store_data[15:0]}} : x_store_data;
  assign byte_l = dmem_resp_data[8*addr_q[1:0] +: 8];
  assign half_l = dmem_resp_data[16*addr_q[1] +: 16];
  assign load_x = size_q == 2'b00 ? {{(N_BITS-8){~uns_q & byte_l[7]}}, byte_l}
                : size_q == 2'b01 ? {{(N_BITS-16){~uns_q & half_l[15]}}, half_l}
                : dmem_resp_data;
  // next-state and result computation; pulses default low, everything else holds
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    size_d = size_q;
    we_d = we_q;
    uns_d = uns_q;
    rd_d = rd_q;
    rd_we_d = rd_we_q;
    w_data_d = w_data_q;
    w_rd_d = w_rd_q;
    w_rd_we_d = w_rd_we_q;
    w_valid_d = 1'b0;
    exc_d = 1'b0;
    case (state_q)
      IDLE: if (x_valid) begin
        if (!is_mem) begin
          w_valid_d = 1'b1;
          w_data_d = x_data;
          w_rd_d = x_rd;
          w_rd_we_d = x_rd_we;
        end else if (bad) begin
          w_valid_d = 1'b1;
          w_rd_d = x_rd;
          w_rd_we_d = 1'b0;
          exc_d = 1'b1;
        end else begin
          state_d = REQ;
          addr_d = x_data;
          wdata_d = wdata_x;
          be_d = be_x;
          size_d = x_mem_size;
          we_d = x_mem_op[1];
          uns_d = x_load_unsigned;
          rd_d = x_rd;
          rd_we_d = x_rd_we;
        end
      end
      REQ: if (dmem_req_ready) begin
        state_d = we_q ? IDLE : WAIT;
        w_valid_d = we_q;
        w_rd_d = we_q ? rd_q : w_rd_q;
        w_rd_we_d = we_q ? 1'b0 : w_rd_we_q;
      end
      WAIT: if (dmem_resp_valid) begin
        state_d = IDLE;
        w_valid_d = 1'b1;
        w_data_d = load_x;
        w_rd_d = rd_q;
        w_rd_we_d = rd_we_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      rd_q <= '0;
      rd_we_q <= 1'b0;
      w_data_q <= '0;
      w_rd_q <= '0;
      w_rd_we_q <= 1'b0;
      w_valid_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      size_q <= size_d;
      we_q <= we_d;
      uns_q <= uns_d;
      rd_q <= rd_d;
      rd_we_q <= rd_we_d;
      w_data_q <= w_data_d;
      w_rd_q <= w_rd_d;
      w_rd_we_q <= w_rd_we_d;
      w_valid_q <= w_valid_d;
      exc_q <= exc_d;
    end
  end
  assign m_ready = state_q == IDLE;
  assign dmem_req_valid = state_q == REQ;
  assign dmem_req_we = we_q;
  assign dmem_req_addr = {addr_q[N_BITS-1:2], 2'b00};
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_be = be_q;
  assign w_valid = w_valid_q;
  assign w_data = w_data_q;
  assign w_rd = w_rd_q;
  assign w_rd_we = w_rd_we_q;
  assign misalign_exc = exc_q;
endmodule

// File: tb/tb_m_stage.sv
// tb_m_stage: directed table and sequence checks of the m_stage memory stage
module tb_m_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic x_valid = 1'b0, m_ready, x_load_unsigned = 1'b0, x_rd_we = 1'b0;
  logic [31:0] x_data = '0, x_store_data = '0;
  logic [1:0] x_mem_op = '0, x_mem_size = '0;
  logic [4:0] x_rd = '0, w_rd;
  logic dmem_req_valid, dmem_req_ready = 1'b0, dmem_req_we, dmem_resp_valid = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_data = '0, w_data;
  logic [3:0] dmem_req_be;
  logic w_valid, w_rd_we, misalign_exc;
  int n_cmp = 0, n_err = 0;

  m_stage dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .m_ready(m_ready), .x_data(x_data),
    .x_store_data(x_store_data), .x_mem_op(x_mem_op), .x_mem_size(x_mem_size),
    .x_load_unsigned(x_load_unsigned), .x_rd(x_rd), .x_rd_we(x_rd_we),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .w_valid(w_valid), .w_data(w_data), .w_rd(w_rd), .w_rd_we(w_rd_we), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic        we;
    logic        chk_data;
    logic        exp_we;
    logic        exp_exc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_access(input string nm, input logic [1:0] op, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] sdata, input logic uns,
                            input logic [4:0] rd, input int rdy_dly, input int resp_dly,
                            input logic [31:0] resp, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_w);
    x_valid = 1'b1; x_mem_op = op; x_mem_size = size; x_data = addr; x_store_data = sdata;
    x_load_unsigned = uns; x_rd = rd; x_rd_we = 1'b1;
    tick();
    x_valid = 1'b0;
    chk({nm, " w_valid@accept"}, 32'(w_valid), 32'd0);
    chk({nm, " req_valid"}, 32'(dmem_req_valid), 32'd1);
    chk({nm, " req_we"}, 32'(dmem_req_we), 32'(op[1]));
    chk({nm, " addr"}, dmem_req_addr, exp_addr);
    chk({nm, " be"}, 32'(dmem_req_be), 32'(exp_be));
    if (op[1]) chk({nm, " wdata"}, dmem_req_wdata, exp_wdata);
    for (int k = 0; k < rdy_dly; k++) begin
      tick();
      chk({nm, " req held"}, 32'(dmem_req_valid), 32'd1);
      chk({nm, " addr held"}, dmem_req_addr, exp_addr);
      chk({nm, " m_ready low"}, 32'(m_ready), 32'd0);
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk({nm, " req dropped"}, 32'(dmem_req_valid), 32'd0);
    if (op[1]) begin
      chk({nm, " store w_valid"}, 32'(w_valid), 32'd1);
      chk({nm, " store w_rd_we"}, 32'(w_rd_we), 32'd0);
      chk({nm, " store m_ready"}, 32'(m_ready), 32'd1);
    end else begin
      chk({nm, " wait m_ready"}, 32'(m_ready), 32'd0);
      for (int k = 0; k < resp_dly; k++) begin
        tick();
        chk({nm, " wait no w_valid"}, 32'(w_valid), 32'd0);
      end
      dmem_resp_valid = 1'b1; dmem_resp_data = resp;
      tick();
      dmem_resp_valid = 1'b0;
      chk({nm, " load w_valid"}, 32'(w_valid), 32'd1);
      chk({nm, " load w_data"}, w_data, exp_w);
      chk({nm, " load w_rd"}, 32'(w_rd), 32'(rd));
      chk({nm, " load w_rd_we"}, 32'(w_rd_we), 32'd1);
      chk({nm, " load m_ready"}, 32'(m_ready), 32'd1);
    end
    tick();
    chk({nm, " w_valid pulse"}, 32'(w_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{32'hDEADBEEF, 2'b00, 2'b10, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h00000055, 2'b11, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h00003001, 2'b01, 2'b10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h00000011, 2'b10, 2'b01, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 2'b01, 2'b11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h00000002, 2'b10, 2'b10, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1};
    repeat (2) tick();
    chk("reset m_ready", 32'(m_ready), 32'd1);
    chk("reset w_valid", 32'(w_valid), 32'd0);
    chk("reset req_valid", 32'(dmem_req_valid), 32'd0);
    chk("reset w_data", w_data, 32'd0);
    chk("reset be", 32'(dmem_req_be), 32'd0);
    chk("reset exc", 32'(misalign_exc), 32'd0);
    rst = 1'b0;
    x_valid = 1'b1; x_data = 32'h1234; x_rd = 5'd5; x_rd_we = 1'b1; x_mem_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alu w_valid", 32'(w_valid), 32'd1);
      chk("alu w_data", w_data, 32'h1234);
      chk("alu w_rd", 32'(w_rd), 32'd5);
      chk("alu m_ready", 32'(m_ready), 32'd1);
    end
    x_valid = 1'b0;
    tick();
    chk("alu pulse end", 32'(w_valid), 32'd0);
    foreach (vecs[i]) begin
      x_valid = 1'b1; x_data = vecs[i].data; x_mem_op = vecs[i].op; x_mem_size = vecs[i].size;
      x_rd = vecs[i].rd; x_rd_we = vecs[i].we;
      tick();
      x_valid = 1'b0;
      chk("vec w_valid", 32'(w_valid), 32'd1);
      chk("vec w_rd_we", 32'(w_rd_we), 32'(vecs[i].exp_we));
      chk("vec exc", 32'(misalign_exc), 32'(vecs[i].exp_exc));
      chk("vec w_rd", 32'(w_rd), 32'(vecs[i].rd));
      chk("vec no req", 32'(dmem_req_valid), 32'd0);
      chk("vec m_ready", 32'(m_ready), 32'd1);
      if (vecs[i].chk_data) chk("vec w_data", w_data, vecs[i].data);
      tick();
      chk("vec pulse end", 32'(w_valid), 32'd0);
      chk("vec exc end", 32'(misalign_exc), 32'd0);
    end
    mem_access("sb", 2'b10, 2'b00, 32'h1003, 32'hAB, 1'b0, 5'd1, 2, 0, 0, 32'h1000, 4'b1000, 32'hABABABAB, 0);
    mem_access("lh", 2'b01, 2'b01, 32'h2002, 0, 1'b0, 5'd10, 0, 2, 32'h80017FFF, 32'h2000, 4'b1100, 0, 32'hFFFF8001);
    mem_access("lhu", 2'b01, 2'b01, 32'h2002, 0, 1'b1, 5'd11, 1, 2, 32'h80017FFF, 32'h2000, 4'b1100, 0, 32'h00008001);
    mem_access("lb", 2'b01, 2'b00, 32'h4001, 0, 1'b0, 5'd12, 0, 0, 32'h12348056, 32'h4000, 4'b0010, 0, 32'hFFFFFF80);
    mem_access("lbu", 2'b01, 2'b00, 32'h4003, 0, 1'b1, 5'd13, 0, 1, 32'hF0000000, 32'h4000, 4'b1000, 0, 32'h000000F0);
    mem_access("lw", 2'b01, 2'b10, 32'h6000, 0, 1'b0, 5'd14, 1, 0, 32'h89ABCDEF, 32'h6000, 4'b1111, 0, 32'h89ABCDEF);
    mem_access("sw", 2'b10, 2'b10, 32'h5000, 32'hCAFEF00D, 1'b0, 5'd15, 0, 0, 0, 32'h5000, 4'b1111, 32'hCAFEF00D, 0);
    mem_access("sh", 2'b10, 2'b01, 32'h7002, 32'h1234BEEF, 1'b0, 5'd16, 1, 0, 0, 32'h7000, 4'b1100, 32'hBEEFBEEF, 0);
    x_valid = 1'b1; x_mem_op = 2'b01; x_mem_size = 2'b10; x_data = 32'h8000; x_rd = 5'd20; x_rd_we = 1'b1;
    tick();
    x_valid = 1'b0; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("rst pre wait", 32'(m_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_data = 32'hFFFF;
    tick();
    dmem_resp_valid = 1'b0;
    chk("rst late w_valid", 32'(w_valid), 32'd0);
    chk("rst m_ready", 32'(m_ready), 32'd1);
    chk("rst req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst w_data", w_data, 32'd0);
    chk("rst w_rd", 32'(w_rd), 32'd0);
    chk("rst w_rd_we", 32'(w_rd_we), 32'd0);
    chk("rst addr", dmem_req_addr, 32'd0);
    chk("rst wdata", dmem_req_wdata, 32'd0);
    chk("rst req_we", 32'(dmem_req_we), 32'd0);
    chk("rst exc", 32'(misalign_exc), 32'd0);
    tick();
    chk("rst still idle", 32'(w_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
